// File: rtl/ycr1_wbb_burst_master.sv
// Wishbone burst initiator: reads issue one lack-terminated burst, writes issue single-beat accesses.
// Define YCR1_WBB_TIMEOUT_EN to add the no-ack watchdog that aborts with err_o/tmo_o.
module ycr1_wbb_burst_master #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int BW    = 4,
  parameter int BL    = 10,
  parameter int TMO_W = 8
) (
  input  logic          wbm_clk_i,
  input  logic          wbm_rst_n,
  input  logic          req_val_i,
  output logic          req_rdy_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_adr_i,
  input  logic [BL-1:0] req_bl_i,
  input  logic [BW-1:0] req_sel_i,
  input  logic          wdat_val_i,
  input  logic [DW-1:0] wdat_i,
  output logic          wdat_rdy_o,
  output logic          rdat_val_o,
  output logic [DW-1:0] rdat_o,
  output logic          rdat_last_o,
  output logic          done_o,
  output logic          err_o,
  output logic          tmo_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [DW-1:0] wbm_dat_o,
  output logic [BW-1:0] wbm_sel_o,
  output logic [BL-1:0] wbm_bl_o,
  input  logic [DW-1:0] wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_lack_i,
  input  logic          wbm_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [AW-1:0] ADR_INC = AW'(DW / 8);
  localparam logic [BL-1:0] BL_ONE  = BL'(1);
  localparam logic [BL:0]   CNT_MAX = '1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_live;
  logic [AW-1:0] r_adr;
  logic [BL-1:0] r_bl;
  logic [BW-1:0] r_sel;
  logic [BL:0]   r_cnt;
  logic          r_err_seen;
  logic          r_len_err;
  logic          r_tmo;

  logic          w_accept;
  logic          w_stb;
  logic          w_ack;
  logic [BL:0]   w_cnt_inc;
  logic          w_cnt_at_bl;
  logic          w_tmo_hit;

  assign w_accept    = (r_state == ST_IDLE) && r_live && req_val_i;
  assign w_stb       = (r_state == ST_RD) || ((r_state == ST_WR) && wdat_val_i);
  assign w_ack       = w_stb && wbm_ack_i;
  // Saturating so a runaway responder cannot wrap back onto a matching count.
  assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_cnt_at_bl = (w_cnt_inc == {1'b0, r_bl});

`ifdef YCR1_WBB_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo_cnt;

  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_accept || w_ack) begin
      r_tmo_cnt <= '0;
    end else if (w_stb) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Abort on the stalled cycle that would make the counter all-ones.
  assign w_tmo_hit = w_stb && !w_ack && (r_tmo_cnt == {{(TMO_W-1){1'b1}}, 1'b0});
`else
  // TMO_W only sizes the watchdog; this constant-false compare keeps it referenced.
  assign w_tmo_hit = (TMO_W < 0);
`endif

  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_rdy_o   = 1'b0;
    wdat_rdy_o  = 1'b0;
    rdat_val_o  = 1'b0;
    rdat_o      = '0;
    rdat_last_o = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    tmo_o       = 1'b0;
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    wbm_we_o    = 1'b0;
    wbm_adr_o   = '0;
    wbm_dat_o   = '0;
    wbm_sel_o   = '0;
    wbm_bl_o    = '0;
    case (r_state)
      ST_IDLE: begin
        req_rdy_o = r_live;
        if (w_accept) begin
          w_state_nxt = req_we_i ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_adr_o = r_adr;
        wbm_sel_o = r_sel;
        wbm_bl_o  = r_bl;
        if (wbm_ack_i) begin
          rdat_val_o  = 1'b1;
          rdat_o      = wbm_dat_i;
          rdat_last_o = wbm_lack_i;
          if (wbm_lack_i) begin
            w_state_nxt = ST_DONE;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_WR: begin
        wbm_cyc_o = wdat_val_i;
        wbm_stb_o = wdat_val_i;
        wbm_we_o  = 1'b1;
        wbm_adr_o = r_adr;
        wbm_dat_o = wdat_i;
        wbm_sel_o = r_sel;
        wbm_bl_o  = BL_ONE;
        if (w_ack) begin
          wdat_rdy_o = 1'b1;
          if (w_cnt_at_bl) begin
            w_state_nxt = ST_DONE;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o      = 1'b1;
        err_o       = r_err_seen | r_len_err | r_tmo;
        tmo_o       = r_tmo;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
    if (!wbm_rst_n) begin
      r_live     <= 1'b0;
      r_adr      <= '0;
      r_bl       <= '0;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_err_seen <= 1'b0;
      r_len_err  <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_adr      <= req_adr_i;
        r_bl       <= (req_bl_i == '0) ? BL_ONE : req_bl_i;
        r_sel      <= req_sel_i;
        r_cnt      <= '0;
        r_err_seen <= 1'b0;
        r_len_err  <= 1'b0;
        r_tmo      <= 1'b0;
      end else begin
        if (w_ack) begin
          r_cnt <= w_cnt_inc;
          if (wbm_err_i) begin
            r_err_seen <= 1'b1;
          end
          if (r_state == ST_WR) begin
            r_adr <= r_adr + ADR_INC;
          end
          // Short burst (lack early/late) or bl-th beat arriving without lack.
          if ((r_state == ST_RD) && (wbm_lack_i ? !w_cnt_at_bl : w_cnt_at_bl)) begin
            r_len_err <= 1'b1;
          end
        end
        if (w_tmo_hit) begin
          r_tmo <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ycr1_wbb_burst_master.sv
// Randomized bench for ycr1_wbb_burst_master with a transaction-level expectation model.
// Exercises the watchdog abort as well when YCR1_WBB_TIMEOUT_EN is defined.
module tb_ycr1_wbb_burst_master;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int BL    = 10;
  localparam int TMO_W = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_val = 1'b0;
  logic          req_rdy;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_adr = '0;
  logic [BL-1:0] req_bl = '0;
  logic [BW-1:0] req_sel = '0;
  logic          wdat_val = 1'b0;
  logic [DW-1:0] wdat = '0;
  logic          wdat_rdy;
  logic          rdat_val;
  logic [DW-1:0] rdat;
  logic          rdat_last;
  logic          done;
  logic          err;
  logic          tmo;
  logic          wbm_cyc;
  logic          wbm_stb;
  logic          wbm_we;
  logic [AW-1:0] wbm_adr;
  logic [DW-1:0] wbm_dat_o;
  logic [BW-1:0] wbm_sel;
  logic [BL-1:0] wbm_bl;
  logic [DW-1:0] wbm_dat_i = '0;
  logic          wbm_ack = 1'b0;
  logic          wbm_lack = 1'b0;
  logic          wbm_err = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  ycr1_wbb_burst_master #(.AW(AW), .DW(DW), .BW(BW), .BL(BL), .TMO_W(TMO_W)) u_dut (
    .wbm_clk_i   (clk),
    .wbm_rst_n   (rst_n),
    .req_val_i   (req_val),
    .req_rdy_o   (req_rdy),
    .req_we_i    (req_we),
    .req_adr_i   (req_adr),
    .req_bl_i    (req_bl),
    .req_sel_i   (req_sel),
    .wdat_val_i  (wdat_val),
    .wdat_i      (wdat),
    .wdat_rdy_o  (wdat_rdy),
    .rdat_val_o  (rdat_val),
    .rdat_o      (rdat),
    .rdat_last_o (rdat_last),
    .done_o      (done),
    .err_o       (err),
    .tmo_o       (tmo),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_stb_o   (wbm_stb),
    .wbm_we_o    (wbm_we),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_sel_o   (wbm_sel),
    .wbm_bl_o    (wbm_bl),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack),
    .wbm_lack_i  (wbm_lack),
    .wbm_err_i   (wbm_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive a request for one cycle; it must be accepted in that cycle.
  task automatic issue_req(input logic we, input logic [AW-1:0] adr, input int bl_req,
                           input logic [BW-1:0] sel);
    @(posedge clk); #1;
    req_val = 1'b1;
    req_we  = we;
    req_adr = adr;
    req_bl  = BL'(bl_req);
    req_sel = sel;
    @(negedge clk);
    check("req_rdy_accept", req_rdy, 1);
    @(posedge clk); #1;
    req_val = 1'b0;
    req_adr = $urandom;
    req_bl  = BL'($urandom);
    req_sel = BW'($urandom);
  endtask

  // Checks the DONE cycle and the ready cycle following it.
  task automatic finish_txn(input logic exp_err, input logic exp_tmo);
    wbm_ack  = 1'b0;
    wbm_lack = 1'b0;
    wbm_err  = 1'b0;
    wdat_val = 1'b0;
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_err", err, exp_err);
    check("done_tmo", tmo, exp_tmo);
    check("done_stb_low", {wbm_cyc, wbm_stb}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_done_rdy", req_rdy, 1);
    check("post_done_pulse", done, 0);
  endtask

  // Responder ends the burst with lack on beat nbeats; err_beat (1-based, 0=none) carries wbm_err_i.
  task automatic run_read(input logic [AW-1:0] adr, input int bl_req, input int nbeats,
                          input int err_beat, input int ack_pct);
    int eff_bl;
    int beat;
    int cycles;
    logic exp_err;
    logic fin;
    logic [DW-1:0] d;
    logic [BW-1:0] sel;
    eff_bl  = (bl_req == 0) ? 1 : bl_req;
    exp_err = (nbeats != eff_bl);
    beat    = 0;
    cycles  = 0;
    fin     = 1'b0;
    sel     = BW'($urandom);
    issue_req(1'b0, adr, bl_req, sel);
    while (!fin) begin
      if (cycles > 1000) begin
        check("rd_cycle_bound", 0, 1);
        break;
      end
      cycles++;
      d         = $urandom;
      wbm_dat_i = d;
      wbm_ack   = ($urandom_range(99) < ack_pct);
      wbm_lack  = wbm_ack && (beat + 1 == nbeats);
      wbm_err   = wbm_ack && (beat + 1 == err_beat);
      @(negedge clk);
      check("rd_cyc_stb", {wbm_cyc, wbm_stb, wbm_we}, 3'b110);
      check("rd_adr", wbm_adr, adr);
      check("rd_bl", wbm_bl, eff_bl);
      check("rd_sel", wbm_sel, sel);
      check("rd_val", rdat_val, wbm_ack);
      if (wbm_ack) begin
        check("rd_dat", rdat, d);
        check("rd_last", rdat_last, wbm_lack);
      end
      @(posedge clk); #1;
      if (wbm_ack) begin
        beat++;
        if (wbm_err) exp_err = 1'b1;
        if (wbm_lack) fin = 1'b1;
      end
    end
    finish_txn(exp_err, 1'b0);
  endtask

  task automatic run_write(input logic [AW-1:0] adr, input int bl_req, input int val_pct,
                           input int ack_pct, input int err_pct);
    int eff_bl;
    int i;
    int cycles;
    logic exp_err;
    logic [AW-1:0] exp_adr;
    logic [DW-1:0] dq[$];
    logic [BW-1:0] sel;
    eff_bl  = (bl_req == 0) ? 1 : bl_req;
    exp_err = 1'b0;
    exp_adr = adr;
    i       = 0;
    cycles  = 0;
    sel     = BW'($urandom);
    for (int k = 0; k < eff_bl; k++) dq.push_back($urandom);
    issue_req(1'b1, adr, bl_req, sel);
    while (i < eff_bl) begin
      if (cycles > 1000) begin
        check("wr_cycle_bound", 0, 1);
        break;
      end
      cycles++;
      wdat_val = ($urandom_range(99) < val_pct);
      wdat     = dq[i];
      wbm_ack  = wdat_val && ($urandom_range(99) < ack_pct);
      wbm_err  = wbm_ack && ($urandom_range(99) < err_pct);
      wbm_lack = $urandom_range(1);
      @(negedge clk);
      check("wr_stb", {wbm_cyc, wbm_stb}, {wdat_val, wdat_val});
      check("wr_rdy", wdat_rdy, wbm_ack);
      check("wr_rd_quiet", rdat_val, 0);
      if (wdat_val) begin
        check("wr_we", wbm_we, 1);
        check("wr_adr", wbm_adr, exp_adr);
        check("wr_dat", wbm_dat_o, dq[i]);
        check("wr_bl", wbm_bl, 1);
        check("wr_sel", wbm_sel, sel);
      end
      @(posedge clk); #1;
      if (wbm_ack) begin
        i++;
        exp_adr = exp_adr + AW'(DW / 8);
        if (wbm_err) exp_err = 1'b1;
      end
    end
    finish_txn(exp_err, 1'b0);
  endtask

`ifdef YCR1_WBB_TIMEOUT_EN
  task automatic run_timeout(input logic [AW-1:0] adr);
    int stb_cycles;
    stb_cycles = 0;
    issue_req(1'b0, adr, 2, 4'hF);
    wbm_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!wbm_stb || stb_cycles > 1000) break;
      stb_cycles++;
      @(posedge clk); #1;
    end
    check("tmo_stb_cycles", stb_cycles, (1 << TMO_W) - 1);
    check("tmo_done", done, 1);
    check("tmo_err", err, 1);
    check("tmo_flag", tmo, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("tmo_post_rdy", req_rdy, 1);
  endtask
`endif

  initial begin
    #1;
    check("rst_req_rdy", req_rdy, 0);
    check("rst_outputs", {wbm_cyc, wbm_stb, wbm_we, done, err, tmo, rdat_val, wdat_rdy}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_req_rdy", req_rdy, 1);
    check("idle_cyc", wbm_cyc, 0);

    run_read(32'h0000_1000, 4, 4, 0, 70);
    run_write(32'h0000_2000, 3, 60, 70, 0);
    run_read(32'h0000_1100, 4, 2, 0, 100);
    run_read(32'h0000_1200, 2, 2, 1, 100);
    run_read(32'h0000_1300, 2, 4, 0, 80);
    run_write(32'hFFFF_FFF8, 4, 100, 100, 0);
    run_write(32'h0000_5000, 0, 100, 50, 0);

    for (int t = 0; t < 12; t++) begin
      int blr;
      int nb;
      blr = $urandom_range(6);
      if ($urandom_range(1) == 1) begin
        nb = ((blr == 0) ? 1 : blr) + $urandom_range(2) - 1;
        if (nb < 1) nb = 1;
        run_read($urandom, blr, nb, $urandom_range(3), 60);
      end else begin
        run_write($urandom, blr, 70, 70, 15);
      end
    end

`ifdef YCR1_WBB_TIMEOUT_EN
    run_timeout(32'h0000_6000);
    run_read(32'h0000_6100, 1, 1, 0, 100);
`endif

    // Reset in the middle of an 8-beat read, during beat 2.
    issue_req(1'b0, 32'h0000_3000, 8, 4'hF);
    wbm_ack = 1'b1;
    wbm_dat_i = $urandom;
    @(posedge clk); #1;
    wbm_dat_i = $urandom;
    @(negedge clk);
    check("mid_burst_stb", wbm_stb, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {wbm_cyc, wbm_stb, wbm_we, rdat_val, rdat_last, done, err, req_rdy}, 0);
    check("mid_rst_adr", wbm_adr, 0);
    check("mid_rst_bl", wbm_bl, 0);
    wbm_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_rdy", req_rdy, 1);
    run_read(32'h0000_4000, 0, 1, 0, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ycr1_wbb_burst_master.md
# ycr1_wbb_burst_master

Wishbone burst initiator that drives the master port of the async Wishbone bridge from the core clock domain. It turns a simple request/stream interface into Wishbone transactions:
- reads become one burst with a burst count, acked per beat and terminated by lack;
- writes become a sequence of single-beat accesses.

It is used by cache-refill and DMA-style clients that must not hand-build Wishbone cycles.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; address increment per beat = DW/8
- BW, 4, byte-select width
- BL, 10, burst-count width (1 = one DW)
- TMO_W, 8, watchdog counter width (used only with timeout enabled)

Ports:
- wbm_clk_i  in  1  clock
- wbm_rst_n  in  1  reset, asynchronous, active-low
- req_val_i  in  1  request valid
- req_rdy_o  out  1  request accepted when val&&rdy
- req_we_i  in  1  1=write, 0=read
- req_adr_i  in  AW  start byte address
- req_bl_i  in  BL  beat count; 0 treated as 1
- req_sel_i  in  BW  byte enables for all beats
- wdat_val_i  in  1  write beat valid
- wdat_i  in  DW  write beat data
- wdat_rdy_o  out  1  write beat consumed
- rdat_val_o  out  1  read beat valid (no backpressure)
- rdat_o  out  DW  read beat data
- rdat_last_o  out  1  final read beat
- done_o  out  1  1-cycle pulse, transaction finished
- err_o  out  1  error status of finished transaction, valid with done_o
- tmo_o  out  1  timeout status, valid with done_o
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone controls
- wbm_adr_o  out  AW;  wbm_dat_o  out  DW;  wbm_sel_o  out  BW;  wbm_bl_o  out  BL
- wbm_dat_i  in  DW;  wbm_ack_i, wbm_lack_i, wbm_err_i  in  1

## Operation
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - req_rdy_o=1. On accept, latch adr, bl (0→1), sel, we; clear beat counter and error flags.
  - Go to RD if we=0, else WR.
- RD:
  - cyc=stb=1, we=0, adr=start address, bl_o=latched bl; the request is held stable until lack.
  - Each ack: rdat_val_o=ack, rdat_o=dat_i, rdat_last_o=lack (combinational pass-through); beat counter +1.
  - On ack&&lack → DONE. Length error flagged if beats received ≠ bl.
  - ack without lack on the bl-th beat is also a length error. Extra beats are forwarded and counted (saturating).
- WR:
  - stb=cyc=wdat_val_i, we=1, bl_o=1, dat_o=wdat_i, adr=current address.
  - wdat_rdy_o=ack. Each ack: address += DW/8 (mod 2^AW), remaining −1.
  - Ack on the final beat → DONE. lack ignored.
- DONE:
  - cyc=stb=0; done_o=1; err_o = any wbm_err_i seen on an ack | length error | timeout; tmo_o = timeout.
  - Next state IDLE.
- wbm_err_i never aborts a transaction; it is sticky until the next accept.
- Reset (any time, including mid-burst): FSM→IDLE, counters/flags cleared, all outputs 0 except req_rdy_o=1 once out of reset. A partial burst is abandoned.

## Timing
- Request accept at cycle N → cyc/stb high at N+1 (registered state; outputs decode from state and registers).
- Read data latency is zero from wbm_ack_i to rdat_val_o.
- Final ack at cycle M → done_o at M+1 (stb low) → req_rdy_o high at M+2. Minimum request spacing is 3 cycles for bl=1.
- Write ack is expected combinationally with stb; a write beat completes in the cycle where stb&&ack.
- Read beats may be back-to-back every cycle; the consumer must always accept rdat.

## Configuration
- YCR1_WBB_TIMEOUT_EN defined:
  - TMO_W-bit counter, cleared on every ack and on entry to RD/WR; increments each RD/WR cycle with stb=1 and no ack.
  - Reaching all-ones (255 at default) aborts: → DONE with err_o=1, tmo_o=1; cyc/stb drop.
- Undefined: no counter; the block waits indefinitely for ack/lack; tmo_o tied 0.

## Test plan
- Read adr=0x1000, bl=4; responder acks at cycles 2,3,5,6 with lack on 4th → 4 rdat_val pulses, data in order, rdat_last on 4th, done_o next cycle, err_o=0.
- Write adr=0x2000, bl=3, data A/B/C with wdat_val gap → wbm_adr 0x2000/0x2004/0x2008, bl_o=1 each, wdat_rdy only on acks, done_o, err_o=0.
- Read bl=4 but lack on beat 2 → DONE after beat 2, err_o=1, tmo_o=0.
- Read bl=2 with wbm_err_i on beat 1 → both beats forwarded, err_o=1 at done_o.
- Timeout (macro on): read, no ack for 255 cycles → stb drops, done_o with err_o=1, tmo_o=1; next request accepted normally.
- Reset asserted mid read burst (beat 2 of 8) → outputs 0 immediately; after release, a fresh bl=1 read completes correctly; req_bl_i=0 issues bl_o=1.
